// File: rtl/bird_motion_ctrl.sv
// Per-frame bird motion sequencer: erase old row, apply gravity/flap with
// ceiling/ground clamp, then draw the new row through the shared plot unit.
module bird_motion_ctrl #(
    parameter int Y_W     = 7,
    parameter int V_W     = 5,
    parameter int Y_START = 60,
    parameter int Y_MAX   = 112,
    parameter int GRAVITY = 1,
    parameter int FLAP_V  = 6,
    parameter int V_MAX   = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           frame_tick,
    input  logic           run,
    input  logic           flap,
    output logic           draw_req,
    output logic           draw_erase,
    output logic [Y_W-1:0] draw_y,
    input  logic           draw_done,
    output logic [Y_W-1:0] bird_y,
    output logic [V_W-1:0] vel,
    output logic           hit_ground,
    output logic           overrun,
    output logic           busy
);

    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_UPDATE, S_DRAW, S_DEAD} state_t;

    localparam logic signed [V_W:0]   GRAV_S = (V_W+1)'(GRAVITY);
    localparam logic signed [V_W:0]   VMAX_S = (V_W+1)'(V_MAX);
    localparam logic signed [V_W-1:0] FLAP_S = V_W'(-FLAP_V);
    localparam logic signed [Y_W+1:0] YMAX_S = (Y_W+2)'(Y_MAX);

    state_t                state, state_nxt;
    logic                  flap_q, flap_pending;
    logic signed [V_W-1:0] vel_r, vel_nxt, v_new;
    logic signed [Y_W+1:0] y_sum;
    logic [Y_W-1:0]        bird_y_nxt, draw_y_nxt;
    logic                  draw_req_nxt, draw_erase_nxt, hit_nxt;

    // Gravity step with terminal-velocity saturation, evaluated one bit wider.
    function automatic logic signed [V_W-1:0] sat_vel(input logic signed [V_W-1:0] v);
        logic signed [V_W:0] s;
        s = signed'({v[V_W-1], v}) + GRAV_S;
        if (s > VMAX_S)
            return signed'(VMAX_S[V_W-1:0]);
        return signed'(s[V_W-1:0]);
    endfunction

    function automatic logic signed [Y_W+1:0] add_pos(input logic [Y_W-1:0] y,
                                                      input logic signed [V_W-1:0] v);
        return signed'({2'b00, y}) + signed'({{(Y_W+2-V_W){v[V_W-1]}}, v});
    endfunction

    assign busy = (state != S_IDLE);
    assign vel  = vel_r;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            flap_q       <= 1'b0;
            flap_pending <= 1'b0;
            overrun      <= 1'b0;
            hit_ground   <= 1'b0;
            bird_y       <= Y_W'(Y_START);
            vel_r        <= '0;
            draw_req     <= 1'b0;
            draw_erase   <= 1'b0;
            draw_y       <= '0;
        end else begin
            state      <= state_nxt;
            flap_q     <= flap;
            hit_ground <= hit_nxt;
            bird_y     <= bird_y_nxt;
            vel_r      <= vel_nxt;
            draw_req   <= draw_req_nxt;
            draw_erase <= draw_erase_nxt;
            draw_y     <= draw_y_nxt;
            // Pending flap is consumed by the update, so edges only accumulate outside it.
            if (state == S_UPDATE)
                flap_pending <= 1'b0;
            else if (flap && !flap_q && run && state != S_DEAD)
                flap_pending <= 1'b1;
            if (frame_tick && run && busy && state != S_DEAD)
                overrun <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (frame_tick && run) state_nxt = S_ERASE;
            S_ERASE:  if (draw_done)         state_nxt = S_UPDATE;
            S_UPDATE:                        state_nxt = S_DRAW;
            S_DRAW:   if (draw_done)         state_nxt = hit_ground ? S_DEAD : S_IDLE;
            S_DEAD:                          state_nxt = S_DEAD;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        v_new          = flap_pending ? FLAP_S : sat_vel(vel_r);
        y_sum          = add_pos(bird_y, v_new);
        bird_y_nxt     = bird_y;
        vel_nxt        = vel_r;
        hit_nxt        = hit_ground;
        draw_req_nxt   = draw_req;
        draw_erase_nxt = draw_erase;
        draw_y_nxt     = draw_y;
        case (state)
            S_IDLE: begin
                if (frame_tick && run) begin
                    draw_req_nxt   = 1'b1;
                    draw_erase_nxt = 1'b1;
                    draw_y_nxt     = bird_y;
                end
            end
            S_ERASE, S_DRAW: begin
                if (draw_done) draw_req_nxt = 1'b0;
            end
            S_UPDATE: begin
                if (y_sum[Y_W+1]) begin
                    bird_y_nxt = '0;
                    vel_nxt    = '0;
                end else if (y_sum >= YMAX_S) begin
                    bird_y_nxt = Y_W'(Y_MAX);
                    vel_nxt    = '0;
                    hit_nxt    = 1'b1;
                end else begin
                    bird_y_nxt = y_sum[Y_W-1:0];
                    vel_nxt    = v_new;
                end
                draw_req_nxt   = 1'b1;
                draw_erase_nxt = 1'b0;
                draw_y_nxt     = bird_y_nxt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl: table of whole frames plus hand-written
// sequences for hold, overrun, run gating and reset mid-draw.
module tb_bird_motion_ctrl;

    logic       clk = 1'b0;
    logic       resetn, frame_tick, run, flap, draw_done;
    logic       draw_req, draw_erase, hit_ground, overrun, busy;
    logic [6:0] draw_y, bird_y;
    logic [4:0] vel;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit rst;
        int nflap;
        int y_old;
        int y_new;
        int v_new;
        bit hit;
    } frame_t;

    frame_t tbl[27];

    bird_motion_ctrl dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .run(run), .flap(flap),
        .draw_req(draw_req), .draw_erase(draw_erase), .draw_y(draw_y),
        .draw_done(draw_done), .bird_y(bird_y), .vel(vel),
        .hit_ground(hit_ground), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int svel();
        return int'($signed(vel));
    endfunction

    task automatic do_reset();
        resetn = 1'b0; frame_tick = 1'b0; flap = 1'b0; draw_done = 1'b0;
        step();
        chk("rst_bird_y", int'(bird_y), 60);
        chk("rst_vel", svel(), 0);
        chk("rst_draw_req", int'(draw_req), 0);
        chk("rst_hit", int'(hit_ground), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_busy", int'(busy), 0);
        resetn = 1'b1;
        step();
    endtask

    task automatic wait_draw_req();
        int waited = 0;
        while (!draw_req && waited < 10) begin
            step();
            waited++;
        end
        chk("draw_req_timeout", int'(draw_req), 1);
    endtask

    task automatic do_frame(input frame_t f);
        int seen;
        for (int i = 0; i < f.nflap; i++) begin
            flap = 1'b1; step();
            flap = 1'b0; step();
        end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("erase_req", int'(draw_req), 1);
        chk("erase_flag", int'(draw_erase), 1);
        chk("erase_y", int'(draw_y), f.y_old);
        draw_done = 1'b1; step(); draw_done = 1'b0;
        chk("erase_drop", int'(draw_req), 0);
        wait_draw_req();
        chk("draw_flag", int'(draw_erase), 0);
        chk("draw_y", int'(draw_y), f.y_new);
        draw_done = 1'b1; step(); draw_done = 1'b0;
        chk("draw_drop", int'(draw_req), 0);
        chk("bird_y", int'(bird_y), f.y_new);
        chk("vel", svel(), f.v_new);
        chk("hit_ground", int'(hit_ground), int'(f.hit));
        chk("busy_after", int'(busy), int'(f.hit));
        if (f.hit) begin
            seen = 0;
            frame_tick = 1'b1; flap = 1'b1; step(); frame_tick = 1'b0; flap = 1'b0;
            for (int i = 0; i < 6; i++) begin
                seen += int'(draw_req);
                step();
            end
            chk("dead_no_req", seen, 0);
            chk("dead_bird_y", int'(bird_y), f.y_new);
            chk("dead_busy", int'(busy), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; frame_tick = 1'b0; run = 1'b1; flap = 1'b0; draw_done = 1'b0;

        // Gentle fall, then a double-edge flap that must count once.
        tbl[0]  = '{1, 0, 60, 61, 1, 0};
        tbl[1]  = '{0, 0, 61, 63, 2, 0};
        tbl[2]  = '{0, 0, 63, 66, 3, 0};
        tbl[3]  = '{0, 2, 66, 60, -6, 0};
        // Free fall to terminal velocity, then ground clamp.
        tbl[4]  = '{1, 0, 60, 61, 1, 0};
        tbl[5]  = '{0, 0, 61, 63, 2, 0};
        tbl[6]  = '{0, 0, 63, 66, 3, 0};
        tbl[7]  = '{0, 0, 66, 70, 4, 0};
        tbl[8]  = '{0, 0, 70, 75, 5, 0};
        tbl[9]  = '{0, 0, 75, 81, 6, 0};
        tbl[10] = '{0, 0, 81, 88, 7, 0};
        tbl[11] = '{0, 0, 88, 95, 7, 0};
        tbl[12] = '{0, 0, 95, 102, 7, 0};
        tbl[13] = '{0, 0, 102, 109, 7, 0};
        tbl[14] = '{0, 0, 109, 112, 0, 1};
        // Climb to the ceiling: exact zero keeps velocity, below zero clamps.
        tbl[15] = '{1, 1, 60, 54, -6, 0};
        tbl[16] = '{0, 1, 54, 48, -6, 0};
        tbl[17] = '{0, 1, 48, 42, -6, 0};
        tbl[18] = '{0, 1, 42, 36, -6, 0};
        tbl[19] = '{0, 1, 36, 30, -6, 0};
        tbl[20] = '{0, 1, 30, 24, -6, 0};
        tbl[21] = '{0, 1, 24, 18, -6, 0};
        tbl[22] = '{0, 1, 18, 12, -6, 0};
        tbl[23] = '{0, 1, 12, 6, -6, 0};
        tbl[24] = '{0, 1, 6, 0, -6, 0};
        tbl[25] = '{0, 1, 0, 0, 0, 0};
        tbl[26] = '{0, 0, 0, 1, 1, 0};

        for (int k = 0; k < 27; k++) begin
            if (tbl[k].rst) do_reset();
            do_frame(tbl[k]);
        end

        // Held button: one flap on the first frame only.
        flap = 1'b1; step();
        do_frame('{0, 0, 1, 0, 0, 0});
        do_frame('{0, 0, 0, 1, 1, 0});
        flap = 1'b0; step();

        // Tick during a stalled erase: overrun, single update, no queued frame.
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("ovr_erase_req", int'(draw_req), 1);
        for (int i = 0; i < 20; i++) begin
            frame_tick = (i == 5);
            step();
        end
        frame_tick = 1'b0;
        chk("ovr_hold_req", int'(draw_req), 1);
        chk("ovr_hold_y", int'(draw_y), 1);
        chk("ovr_flag", int'(overrun), 1);
        draw_done = 1'b1; step(); draw_done = 1'b0;
        wait_draw_req();
        draw_done = 1'b1; step(); draw_done = 1'b0;
        chk("ovr_bird_y", int'(bird_y), 3);
        chk("ovr_vel", svel(), 2);
        chk("ovr_idle", int'(busy), 0);
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                seen += int'(draw_req);
                step();
            end
            chk("ovr_no_queue", seen, 0);
        end

        // run=0 ignores ticks; stray draw_done in idle is ignored.
        run = 1'b0; frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("norun_req", int'(draw_req), 0);
        chk("norun_busy", int'(busy), 0);
        run = 1'b1;
        draw_done = 1'b1; step(); draw_done = 1'b0;
        chk("stray_done_busy", int'(busy), 0);
        chk("stray_done_y", int'(bird_y), 3);

        // Reset while the draw request is outstanding.
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        draw_done = 1'b1; step(); draw_done = 1'b0;
        step();
        chk("mid_draw_req", int'(draw_req), 1);
        chk("mid_draw_flag", int'(draw_erase), 0);
        resetn = 1'b0; step();
        chk("mid_rst_req", int'(draw_req), 0);
        chk("mid_rst_y", int'(bird_y), 60);
        chk("mid_rst_vel", svel(), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        resetn = 1'b1; step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
